// File: rtl/matmul_job_sequencer.sv
// Job front-end for the 4x4 matmul + 2x2 average-pool engine: streams eight operand words
// into the shared memory, kicks the engine, tracks its ready line and returns the pooled word.
module matmul_job_sequencer #(
  parameter int         DATA_W      = 32,
  parameter logic [9:0] A_BASE      = 10'h000,
  parameter logic [9:0] B_BASE      = 10'h100,
  parameter logic [9:0] C_BASE      = 10'h200,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              mem_we,
  output logic [9:0]        mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [9:0]        mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mm_kick,
  input  logic              mm_ready,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              err_timeout,
  output logic [7:0]        job_cnt
);
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, FLUSH, KICK, WAIT_LOW, WAIT_HIGH, RD_C, CAP_C, OUT
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              s_ready_q, s_ready_d;
  logic              we_q, we_d;
  logic [9:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              accept;

  // Beats 0-3 are A rows, beats 4-7 are B columns.
  function automatic logic [9:0] beat_addr(input logic [2:0] idx);
    return idx[2] ? (B_BASE + 10'(idx[1:0])) : (A_BASE + 10'(idx[1:0]));
  endfunction

  assign accept = s_ready_q & s_valid;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wd_d      = wd_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    mm_kick   = 1'b0;
    mem_re    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = beat_addr(3'd0);
          wdata_d = s_data;
          idx_d   = 3'd1;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = beat_addr(idx_q);
          wdata_d = s_data;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = FLUSH;
        end
      end
      FLUSH: state_d = KICK;
      KICK: begin
        // The engine only takes a kick while it reports idle; the watchdog stays parked.
        if (mm_ready) begin
          mm_kick = 1'b1;
          wd_d    = '0;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        wd_d = wd_q + WD_W'(1);
        if (!mm_ready) state_d = WAIT_HIGH;
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_HIGH: begin
        wd_d = wd_q + WD_W'(1);
        if (mm_ready) state_d = RD_C;
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RD_C: begin
        mem_re  = 1'b1;
        state_d = CAP_C;
      end
      CAP_C: begin
        m_data_d  = mem_rdata;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = cnt_q + 8'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // s_ready is registered so it is low while rstn is asserted.
  assign s_ready_d = (state_d == IDLE) || (state_d == LOAD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wd_q      <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign mem_we      = we_q;
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign mem_raddr   = C_BASE;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;
  assign job_cnt     = cnt_q;

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Bench for matmul_job_sequencer: behavioural memory + engine model, scoreboarded writes and results.
`timescale 1ns/1ps
module tb_matmul_job_sequencer;
  localparam logic [9:0] A_BASE      = 10'h000;
  localparam logic [9:0] B_BASE      = 10'h100;
  localparam logic [9:0] C_BASE      = 10'h200;
  localparam int         TIMEOUT_CYC = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic [9:0]  mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic        mm_kick;
  logic        mm_ready = 1'b1;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        busy;
  logic        err_timeout;
  logic [7:0]  job_cnt;

  always #5 clk = ~clk;

  matmul_job_sequencer #(
    .DATA_W(32), .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mm_kick(mm_kick), .mm_ready(mm_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .err_timeout(err_timeout), .job_cnt(job_cnt)
  );

  int checks = 0;
  int passes = 0;
  int kick_cnt = 0;
  int re_cnt = 0;
  int result_cnt = 0;
  int model_jobs = 0;
  bit eng_dead = 1'b0;
  bit mr_hold = 1'b0;
  bit mr_rand = 1'b0;
  logic [41:0] wr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:1023];
  int eng_st = 0;
  int eng_lat = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: C = A x B over unsigned bytes, then 2x2 mean (truncated), packed {P11,P10,P01,P00}.
  function automatic logic [31:0] ref_pool(input logic [7:0][31:0] w);
    int c[4][4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        c[i][j] = 0;
        for (int k = 0; k < 4; k++)
          c[i][j] += int'(w[i][8*k +: 8]) * int'(w[4+j][8*k +: 8]);
      end
    for (int pr = 0; pr < 2; pr++)
      for (int pc = 0; pc < 2; pc++)
        r[8*(2*pr+pc) +: 8] = 8'((c[2*pr][2*pc] + c[2*pr][2*pc+1] + c[2*pr+1][2*pc] + c[2*pr+1][2*pc+1]) / 4);
    return r;
  endfunction

  function automatic logic [7:0][31:0] ops_from_mem();
    logic [7:0][31:0] w;
    for (int i = 0; i < 4; i++) begin
      w[i]   = mem[int'(A_BASE) + i];
      w[4+i] = mem[int'(B_BASE) + i];
    end
    return w;
  endfunction

  // Operand memory plus engine: ready drops 2 cycles after a kick, C written as ready returns.
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr];
    case (eng_st)
      0: if (mm_kick && !eng_dead) eng_st <= 1;
      1: begin
        mm_ready <= 1'b0;
        eng_lat  <= $urandom_range(1, 8);
        eng_st   <= 2;
      end
      default: begin
        if (eng_lat == 0) begin
          mem[C_BASE] <= ref_pool(ops_from_mem());
          mm_ready    <= 1'b1;
          eng_st      <= 0;
        end else eng_lat <= eng_lat - 1;
      end
    endcase
  end

  initial forever begin
    @(posedge clk); #1;
    m_ready = mr_hold ? 1'b0 : (mr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: write timing/content, result scoreboard, output hold, job counter, busy.
  initial begin : monitor
    logic [41:0] e;
    logic [31:0] x;
    logic [31:0] md_prev;
    bit acc_pend, mv_prev, hs_prev, hs;
    acc_pend = 0; mv_prev = 0; hs_prev = 0; md_prev = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        acc_pend = 0; mv_prev = 0; hs_prev = 0; model_jobs = 0;
        wr_q.delete();
      end else begin
        if (acc_pend || mem_we) begin
          check(mem_we == acc_pend, "write_one_cycle_after_beat", 64'(mem_we), 64'(acc_pend));
          if (mem_we) begin
            if (wr_q.size() == 0) check(1'b0, "unexpected_write", 64'(mem_waddr), 64'hx);
            else begin
              e = wr_q.pop_front();
              check(mem_waddr == e[41:32], "write_addr", 64'(mem_waddr), 64'(e[41:32]));
              check(mem_wdata == e[31:0], "write_data", 64'(mem_wdata), 64'(e[31:0]));
            end
          end
        end
        acc_pend = s_valid && s_ready;
        if (mem_re) begin
          re_cnt++;
          check(mem_raddr == C_BASE, "read_addr", 64'(mem_raddr), 64'(C_BASE));
        end
        if (mm_kick) kick_cnt++;
        if (!mm_ready) check(busy == 1'b1, "busy_while_engine_runs", 64'(busy), 64'd1);
        if (hs_prev) begin
          check(busy == 1'b0, "idle_after_result", 64'(busy), 64'd0);
          check(job_cnt == 8'(model_jobs), "job_cnt", 64'(job_cnt), 64'(8'(model_jobs)));
        end
        if (mv_prev) begin
          check(m_valid == 1'b1, "m_valid_held", 64'(m_valid), 64'd1);
          check(m_data == md_prev, "m_data_held", 64'(m_data), 64'(md_prev));
        end
        if (m_valid) check(s_ready == 1'b0 && busy == 1'b1, "no_input_while_result_pending",
                           64'({s_ready, busy}), 64'b01);
        hs = m_valid && m_ready;
        if (hs) begin
          if (exp_q.size() == 0) check(1'b0, "unexpected_result", 64'(m_data), 64'hx);
          else begin
            x = exp_q.pop_front();
            check(m_data == x, "result_data", 64'(m_data), 64'(x));
          end
          model_jobs++;
          result_cnt++;
        end
        mv_prev = m_valid && !m_ready;
        md_prev = m_data;
        hs_prev = hs;
      end
    end
  end

  task automatic send_job(input logic [7:0][31:0] w, input bit gap, input int nbeats,
                          input bit push_res, input logic [31:0] expv);
    int i = 0;
    int stall = 0;
    bit phase = 0;
    bit chk_err = 0;
    while (i < nbeats) begin
      @(posedge clk); #1;
      if (chk_err) begin
        check(err_timeout == 1'b0, "err_cleared_by_first_beat", 64'(err_timeout), 64'd0);
        chk_err = 0;
      end
      if (gap && phase) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_data  = w[i];
      end
      phase = ~phase;
      if (s_valid && s_ready) begin
        wr_q.push_back({(i < 4) ? (A_BASE + 10'(i)) : (B_BASE + 10'(i - 4)), w[i]});
        if (i == 0) chk_err = 1;
        i++;
        stall = 0;
        if (i == 8 && push_res) exp_q.push_back(expv);
      end else if (++stall > 3 * TIMEOUT_CYC) begin
        check(1'b0, "s_ready_wait_expired", 64'(i), 64'd8);
        i = nbeats;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < budget);
    if (n >= budget) check(1'b0, "idle_wait_expired", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [7:0][31:0] rand_words();
    logic [7:0][31:0] w;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    return w;
  endfunction

  initial begin
    #900000;
    $display("FAIL global_time_limit: got %0t expected finish earlier", $time);
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [7:0][31:0] w;
    logic [31:0] d0;
    int n, k0, r0, re0;
    logic [7:0] jc0;

    repeat (2) begin
      @(negedge clk);
      check({s_ready, mem_we, mem_re, mm_kick, m_valid, busy, err_timeout} == 7'd0 &&
            mem_waddr == 0 && mem_wdata == 0 && m_data == 0 && job_cnt == 0,
            "reset_outputs", 64'({s_ready, mem_we, mem_re, mm_kick, m_valid, busy, err_timeout, job_cnt}), 64'd0);
    end
    @(posedge clk); #1 rstn = 1'b1;

    // All-ones job.
    for (int i = 0; i < 8; i++) w[i] = 32'h01010101;
    k0 = kick_cnt;
    send_job(w, 1'b0, 8, 1'b1, 32'h04040404);
    wait_idle(500);
    check(kick_cnt - k0 == 1, "one_kick_per_job", 64'(kick_cnt - k0), 64'd1);
    check(job_cnt == 8'd1, "job_cnt_after_first", 64'(job_cnt), 64'd1);

    // Identity A, ramp B.
    w[0] = 32'h00000001; w[1] = 32'h00000100; w[2] = 32'h00010000; w[3] = 32'h01000000;
    w[4] = 32'h10101010; w[5] = 32'h20202020; w[6] = 32'h30303030; w[7] = 32'h40404040;
    send_job(w, 1'b0, 8, 1'b1, 32'h38183818);
    wait_idle(500);

    // Input gaps, then a 20-cycle output stall.
    @(negedge clk); mr_hold = 1'b1;
    w = rand_words();
    send_job(w, 1'b1, 8, 1'b1, ref_pool(w));
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 200);
    check(m_valid == 1'b1, "result_presented", 64'(m_valid), 64'd1);
    d0 = m_data;
    repeat (20) begin
      @(negedge clk);
      check(m_valid == 1'b1 && m_data == d0 && s_ready == 1'b0, "stall_hold",
            64'({m_valid, s_ready, m_data}), 64'({1'b1, 1'b0, d0}));
    end
    mr_hold = 1'b0;
    wait_idle(500);

    // Engine never drops ready: watchdog abort.
    eng_dead = 1'b1;
    re0 = re_cnt; jc0 = job_cnt; r0 = result_cnt;
    send_job(rand_words(), 1'b0, 8, 1'b0, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!mm_kick && n < 50);
    check(mm_kick == 1'b1, "stub_kick_seen", 64'(mm_kick), 64'd1);
    // err_timeout rises on the TIMEOUT_CYC-th clock edge after the edge that takes the kick.
    n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 3 * TIMEOUT_CYC);
    check(n == TIMEOUT_CYC + 1, "timeout_latency", 64'(n), 64'(TIMEOUT_CYC + 1));
    repeat (5) @(negedge clk);
    check(err_timeout == 1'b1, "err_sticky", 64'(err_timeout), 64'd1);
    check(busy == 1'b0 && s_ready == 1'b1, "idle_after_abort", 64'({busy, s_ready}), 64'b01);
    check(re_cnt == re0, "no_read_on_abort", 64'(re_cnt - re0), 64'd0);
    check(job_cnt == jc0 && result_cnt == r0, "no_result_on_abort", 64'(job_cnt), 64'(jc0));
    eng_dead = 1'b0;
    w = rand_words();
    send_job(w, 1'b0, 8, 1'b1, ref_pool(w));
    wait_idle(500);

    // Reset after beat 5, then one full job.
    send_job(rand_words(), 1'b0, 6, 1'b0, 32'h0);
    @(posedge clk); #1 rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check({s_ready, mem_we, mem_re, mm_kick, m_valid, busy, err_timeout} == 7'd0 &&
            mem_waddr == 0 && mem_wdata == 0 && m_data == 0 && job_cnt == 0,
            "reset_mid_job_outputs", 64'({s_ready, mem_we, mem_re, mm_kick, m_valid, busy, err_timeout, job_cnt}), 64'd0);
    end
    @(posedge clk); #1 rstn = 1'b1;
    r0 = result_cnt;
    w = rand_words();
    send_job(w, 1'b0, 8, 1'b1, ref_pool(w));
    wait_idle(500);
    repeat (3) @(negedge clk);
    check(result_cnt - r0 == 1, "one_result_after_reset", 64'(result_cnt - r0), 64'd1);

    // 256 back-to-back jobs: job_cnt wraps through 255 -> 0 and lands on 1.
    mr_rand = 1'b1;
    r0 = result_cnt;
    for (int j = 0; j < 256; j++) begin
      w = rand_words();
      send_job(w, ($urandom_range(0, 7) == 0), 8, 1'b1, ref_pool(w));
    end
    wait_idle(2000);
    repeat (3) @(negedge clk);
    check(result_cnt - r0 == 256, "results_for_256_jobs", 64'(result_cnt - r0), 64'd256);
    check(job_cnt == 8'd1, "job_cnt_wrapped", 64'(job_cnt), 64'd1);
    check(wr_q.size() == 0, "all_writes_seen", 64'(wr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
